// File: rtl/trashbin_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
// Requester indices, FSM encoding and a one-hot helper for per-requester bits.
package trashbin_bus_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam logic REQ_CORE  = 1'b0;
  localparam logic REQ_DEBUG = 1'b1;

  localparam int TIMEOUT_DEFAULT = 256;

  function automatic logic [1:0] onehot2(
    input logic idx,
    input logic b
  );
    return idx ? {b, 1'b0} : {1'b0, b};
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Requester + memory side signals of the arbiter, packed per the shared port.
// slave = arbiter view, master = the surrounding requesters and memory.
interface memory_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [2*AW-1:0] ReqAddress;
  logic [2*DW-1:0] ReqWriteData;
  logic [1:0]      ReqReadAssert;
  logic [1:0]      ReqWriteAssert;
  logic [DW-1:0]   ReqReadData;
  logic [1:0]      ReqReadOK;
  logic [1:0]      ReqWriteOK;
  logic [1:0]      ReqTimeout;
  logic [AW-1:0]   MemAddressBus;
  logic [DW-1:0]   MemDataWriteBus;
  logic            MemReadAssert;
  logic            MemWriteAssert;
  logic [DW-1:0]   MemDataReadBus;
  logic            MemReadOK;
  logic            MemWriteOK;
  logic            GrantOwner;
  logic            TimeoutSticky;

  modport slave (
    input  ReqAddress, ReqWriteData,
    input  ReqReadAssert, ReqWriteAssert,
    output ReqReadData, ReqReadOK,
    output ReqWriteOK, ReqTimeout,
    output MemAddressBus, MemDataWriteBus,
    output MemReadAssert, MemWriteAssert,
    input  MemDataReadBus, MemReadOK, MemWriteOK,
    output GrantOwner, TimeoutSticky
  );

  modport master (
    output ReqAddress, ReqWriteData,
    output ReqReadAssert, ReqWriteAssert,
    input  ReqReadData, ReqReadOK,
    input  ReqWriteOK, ReqTimeout,
    input  MemAddressBus, MemDataWriteBus,
    input  MemReadAssert, MemWriteAssert,
    output MemDataReadBus, MemReadOK, MemWriteOK,
    input  GrantOwner, TimeoutSticky
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = 1'b0;
    unique case (1'b1)
      (i_req == 2'b11): o_grant = ~i_last;
      (i_req == 2'b10): o_grant = 1'b1;
      default:          o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin owner of one memory port shared by the core and the debug
// loader; a grant lasts a whole transaction and is aborted on timeout.
module memory_bus_arbiter
  import trashbin_bus_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic                 CoreClock,
  input logic                 CoreReset,
  memory_bus_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t    r_state, w_state_nx;
  logic          r_owner, w_owner_nx;
  logic          r_last, w_last_nx;
  logic          r_sticky, w_sticky_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;

  logic [1:0]    w_reqs;
  logic          w_pick, w_valid, w_grant;
  logic          w_ord, w_owr, w_req;
  logic          w_mra, w_mwa;
  logic          w_rok, w_wok, w_ok, w_to;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  assign w_reqs = bus.ReqReadAssert | bus.ReqWriteAssert;

  rr_pick2 u_pick (
    .i_req   (w_reqs),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_valid (w_valid)
  );

  assign w_grant = (r_state == ARB_GRANT);
  assign w_ord   = bus.ReqReadAssert[r_owner];
  assign w_owr   = bus.ReqWriteAssert[r_owner];
  assign w_req   = w_ord | w_owr;

  // Write wins when the owner asserts both.
  assign w_mwa = w_grant & w_owr;
  assign w_mra = w_grant & w_ord & ~w_owr;
  assign w_rok = w_mra & bus.MemReadOK;
  assign w_wok = w_mwa & bus.MemWriteOK;
  assign w_ok  = w_rok | w_wok;
  assign w_to  = w_grant & w_req & ~w_ok
               & (r_cnt == C_LAST);

  assign w_addr  = r_owner ? bus.ReqAddress[2*AW-1:AW]
                           : bus.ReqAddress[AW-1:0];
  assign w_wdata = r_owner ? bus.ReqWriteData[2*DW-1:DW]
                           : bus.ReqWriteData[DW-1:0];

  assign bus.MemAddressBus   = w_grant ? w_addr : '0;
  assign bus.MemDataWriteBus = w_grant ? w_wdata : '0;
  assign bus.MemReadAssert   = w_mra;
  assign bus.MemWriteAssert  = w_mwa;
  assign bus.ReqReadData     = w_grant ? bus.MemDataReadBus : '0;
  assign bus.ReqReadOK       = onehot2(r_owner, w_rok);
  assign bus.ReqWriteOK      = onehot2(r_owner, w_wok);
  assign bus.ReqTimeout      = onehot2(r_owner, w_to);
  assign bus.GrantOwner      = r_owner;
  assign bus.TimeoutSticky   = r_sticky;

  always_comb begin
    w_state_nx  = r_state;
    w_owner_nx  = r_owner;
    w_last_nx   = r_last;
    w_sticky_nx = r_sticky;
    w_cnt_nx    = r_cnt;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_valid) begin
          w_state_nx = ARB_GRANT;
          w_owner_nx = w_pick;
          w_cnt_nx   = '0;
        end
      end
      ARB_GRANT: begin
        if (r_cnt != C_LAST) w_cnt_nx = r_cnt + 1'b1;
        if (w_ok || w_to || !w_req) w_state_nx = ARB_IDLE;
        // A dropped request leaves fairness history untouched.
        if (w_ok || w_to) w_last_nx = r_owner;
        if (w_to) w_sticky_nx = 1'b1;
      end
      default: w_state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) begin
      r_state  <= ARB_IDLE;
      r_owner  <= REQ_CORE;
      r_last   <= REQ_DEBUG;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_owner  <= w_owner_nx;
      r_last   <= w_last_nx;
      r_sticky <= w_sticky_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

endmodule
